// File: rtl/pos_edge_detector.sv
// Per-lane edge detector: rising, falling and any-edge pulses from a level input,
// with an optional input synchronizer and optional output flops.
module pos_edge_detector #(
    parameter int WIDTH       = 1,
    parameter int SYNC_STAGES = 0,
    parameter bit REGISTERED  = 1'b0,
    parameter bit RESET_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sig,
    output logic [WIDTH-1:0] pe,
    output logic [WIDTH-1:0] ne,
    output logic [WIDTH-1:0] ae
);

    logic [WIDTH-1:0] w_sig_s;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] w_pe_c;
    logic [WIDTH-1:0] w_ne_c;
    logic [WIDTH-1:0] w_ae_c;

    generate
        if (SYNC_STAGES == 0) begin : g_no_sync
            assign w_sig_s = sig;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;

            // Sync flops reset to RESET_LEVEL so a held-high input behaves
            // the same at release whether or not the synchronizer is present.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < SYNC_STAGES; i++) begin
                        r_sync[i] <= {WIDTH{RESET_LEVEL}};
                    end
                end else begin
                    r_sync[0] <= sig;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        r_sync[i] <= r_sync[i-1];
                    end
                end
            end

            assign w_sig_s = r_sync[SYNC_STAGES-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= {WIDTH{RESET_LEVEL}};
        end else begin
            r_prev <= w_sig_s;
        end
    end

    assign w_pe_c = w_sig_s & ~r_prev;
    assign w_ne_c = ~w_sig_s & r_prev;
    assign w_ae_c = w_sig_s ^ r_prev;

    generate
        if (REGISTERED) begin : g_reg_out
            logic [WIDTH-1:0] r_pe;
            logic [WIDTH-1:0] r_ne;
            logic [WIDTH-1:0] r_ae;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_pe <= '0;
                    r_ne <= '0;
                    r_ae <= '0;
                end else begin
                    r_pe <= w_pe_c;
                    r_ne <= w_ne_c;
                    r_ae <= w_ae_c;
                end
            end

            assign pe = r_pe;
            assign ne = r_ne;
            assign ae = r_ae;
        end else begin : g_comb_out
            // Consumers must sample these synchronously; they can glitch.
            assign pe = w_pe_c;
            assign ne = w_ne_c;
            assign ae = w_ae_c;
        end
    endgenerate

endmodule

// File: tb/tb_pos_edge_detector.sv
// Scoreboard bench for pos_edge_detector across four parameter sets:
// comb/no-sync, 2-stage sync + registered, reset-level-1, and 4-lane registered.
module tb_pos_edge_detector;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       sig0 = 1'b0, sig1 = 1'b0, sig2 = 1'b0;
    logic [3:0] sig3 = 4'b0000;
    logic       pe0, ne0, ae0;
    logic       pe1, ne1, ae1;
    logic       pe2, ne2, ae2;
    logic [3:0] pe3, ne3, ae3;

    typedef struct packed {
        logic [3:0] pe;
        logic [3:0] ne;
        logic [3:0] ae;
    } obs_t;

    obs_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    pos_edge_detector #(.WIDTH(1), .SYNC_STAGES(0), .REGISTERED(1'b0), .RESET_LEVEL(1'b0)) u0 (
        .clk(clk), .rst_n(rst_n), .sig(sig0), .pe(pe0), .ne(ne0), .ae(ae0));
    pos_edge_detector #(.WIDTH(1), .SYNC_STAGES(2), .REGISTERED(1'b1), .RESET_LEVEL(1'b0)) u1 (
        .clk(clk), .rst_n(rst_n), .sig(sig1), .pe(pe1), .ne(ne1), .ae(ae1));
    pos_edge_detector #(.WIDTH(1), .SYNC_STAGES(0), .REGISTERED(1'b0), .RESET_LEVEL(1'b1)) u2 (
        .clk(clk), .rst_n(rst_n), .sig(sig2), .pe(pe2), .ne(ne2), .ae(ae2));
    pos_edge_detector #(.WIDTH(4), .SYNC_STAGES(0), .REGISTERED(1'b1), .RESET_LEVEL(1'b0)) u3 (
        .clk(clk), .rst_n(rst_n), .sig(sig3), .pe(pe3), .ne(ne3), .ae(ae3));

    function automatic obs_t obs(input int d);
        obs_t o;
        case (d)
            0:       begin o.pe = {3'b000, pe0}; o.ne = {3'b000, ne0}; o.ae = {3'b000, ae0}; end
            1:       begin o.pe = {3'b000, pe1}; o.ne = {3'b000, ne1}; o.ae = {3'b000, ae1}; end
            2:       begin o.pe = {3'b000, pe2}; o.ne = {3'b000, ne2}; o.ae = {3'b000, ae2}; end
            default: begin o.pe = pe3; o.ne = ne3; o.ae = ae3; end
        endcase
        return o;
    endfunction

    function automatic obs_t mk(input logic [3:0] p, input logic [3:0] n, input logic [3:0] a);
        obs_t o;
        o.pe = p; o.ne = n; o.ae = a;
        return o;
    endfunction

    // Drive on the falling edge and settle; the sample point lies 3 ns before the next rising edge.
    task automatic step(input int d, input logic [3:0] s);
        @(negedge clk);
        case (d)
            0:       sig0 = s[0];
            1:       sig1 = s[0];
            2:       sig2 = s[0];
            default: sig3 = s;
        endcase
        #2;
    endtask

    task automatic test_reset();
        obs_t o, e;
        rst_n = 1'b0;
        sig0 = 1'b0; sig1 = 1'b0; sig2 = 1'b0; sig3 = 4'b0000;
        repeat (2) @(negedge clk);
        #2;
        // prev of the RESET_LEVEL=1 lane holds 1, so its comb ne/ae show 1 with sig=0
        sb.push_back(mk(4'h0, 4'h0, 4'h0));
        sb.push_back(mk(4'h0, 4'h0, 4'h0));
        sb.push_back(mk(4'h0, 4'h1, 4'h1));
        sb.push_back(mk(4'h0, 4'h0, 4'h0));
        for (int d = 0; d < 4; d++) begin
            o = obs(d);
            e = sb.pop_front();
            n_vec++;
            if (o !== e) begin
                n_err++;
                $display("FAIL reset dut%0d got pe/ne/ae=%b/%b/%b want %b/%b/%b",
                         d, o.pe, o.ne, o.ae, e.pe, e.ne, e.ae);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_rise_fall();
        logic st [12] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic xp [12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic xn [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        obs_t o, e;
        for (int i = 0; i < 12; i++) begin
            step(0, {3'b000, st[i]});
            sb.push_back(mk({3'b000, xp[i]}, {3'b000, xn[i]}, {3'b000, xp[i] | xn[i]}));
            o = obs(0);
            e = sb.pop_front();
            n_vec++;
            if (o !== e) begin
                n_err++;
                $display("FAIL rise_fall[%0d] got pe/ne/ae=%b/%b/%b want %b/%b/%b",
                         i, o.pe[0], o.ne[0], o.ae[0], e.pe[0], e.ne[0], e.ae[0]);
            end
        end
    endtask

    task automatic test_sync_latency();
        // rise driven at index 1 -> pe seen at index 4; fall at index 7 -> ne seen at index 10
        logic st [13] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic xp [13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic xn [13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        obs_t o, e;
        for (int i = 0; i < 13; i++) begin
            step(1, {3'b000, st[i]});
            sb.push_back(mk({3'b000, xp[i]}, {3'b000, xn[i]}, {3'b000, xp[i] | xn[i]}));
            o = obs(1);
            e = sb.pop_front();
            n_vec++;
            if (o !== e) begin
                n_err++;
                $display("FAIL sync_latency[%0d] got pe/ne/ae=%b/%b/%b want %b/%b/%b",
                         i, o.pe[0], o.ne[0], o.ae[0], e.pe[0], e.ne[0], e.ae[0]);
            end
        end
    endtask

    task automatic test_reset_level();
        obs_t o, e;
        rst_n = 1'b0;
        sig0 = 1'b1; sig2 = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #2;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step(0, 4'h1);
            // RESET_LEVEL=0 lane: one pulse before the first edge after release; RESET_LEVEL=1: none
            sb.push_back(mk({3'b000, i == 0}, 4'h0, {3'b000, i == 0}));
            sb.push_back(mk(4'h0, 4'h0, 4'h0));
            for (int d = 0; d < 3; d += 2) begin
                o = obs(d);
                e = sb.pop_front();
                n_vec++;
                if (o !== e) begin
                    n_err++;
                    $display("FAIL reset_level dut%0d[%0d] got pe/ne/ae=%b/%b/%b want %b/%b/%b",
                             d, i, o.pe[0], o.ne[0], o.ae[0], e.pe[0], e.ne[0], e.ae[0]);
                end
            end
        end
    endtask

    task automatic test_toggle();
        obs_t o, e;
        int   pe_cnt = 0;
        logic s;
        step(0, 4'h0);
        step(0, 4'h0);
        for (int i = 0; i < 8; i++) begin
            s = (i % 2 == 0);
            step(0, {3'b000, s});
            sb.push_back(mk({3'b000, s}, {3'b000, ~s}, 4'h1));
            o = obs(0);
            e = sb.pop_front();
            if (o.pe[0] === 1'b1) pe_cnt++;
            n_vec++;
            if (o !== e) begin
                n_err++;
                $display("FAIL toggle[%0d] got pe/ne/ae=%b/%b/%b want %b/%b/%b",
                         i, o.pe[0], o.ne[0], o.ae[0], e.pe[0], e.ne[0], e.ae[0]);
            end
        end
        n_vec++;
        if (pe_cnt != 4) begin
            n_err++;
            $display("FAIL toggle_pe_count got %0d want 4", pe_cnt);
        end
    endtask

    task automatic test_width4_reset_mid();
        obs_t o, e;
        int   k = 0;
        step(3, 4'b0000); sb.push_back(mk(4'b0000, 4'b0000, 4'b0000));
        o = obs(3); e = sb.pop_front(); n_vec++;
        if (o !== e) begin n_err++; $display("FAIL w4[%0d] got pe/ne/ae=%b/%b/%b want %b/%b/%b", k, o.pe, o.ne, o.ae, e.pe, e.ne, e.ae); end
        k++;
        step(3, 4'b0101); sb.push_back(mk(4'b0000, 4'b0000, 4'b0000));
        o = obs(3); e = sb.pop_front(); n_vec++;
        if (o !== e) begin n_err++; $display("FAIL w4[%0d] got pe/ne/ae=%b/%b/%b want %b/%b/%b", k, o.pe, o.ne, o.ae, e.pe, e.ne, e.ae); end
        k++;
        step(3, 4'b1111); sb.push_back(mk(4'b0101, 4'b0000, 4'b0101));
        o = obs(3); e = sb.pop_front(); n_vec++;
        if (o !== e) begin n_err++; $display("FAIL w4[%0d] got pe/ne/ae=%b/%b/%b want %b/%b/%b", k, o.pe, o.ne, o.ae, e.pe, e.ne, e.ae); end
        k++;
        step(3, 4'b1111); sb.push_back(mk(4'b1010, 4'b0000, 4'b1010));
        o = obs(3); e = sb.pop_front(); n_vec++;
        if (o !== e) begin n_err++; $display("FAIL w4[%0d] got pe/ne/ae=%b/%b/%b want %b/%b/%b", k, o.pe, o.ne, o.ae, e.pe, e.ne, e.ae); end
        k++;
        // reset lands mid-pulse, between clock edges
        #1 rst_n = 1'b0;
        #1;
        sb.push_back(mk(4'b0000, 4'b0000, 4'b0000));
        o = obs(3); e = sb.pop_front(); n_vec++;
        if (o !== e) begin n_err++; $display("FAIL w4_mid_reset got pe/ne/ae=%b/%b/%b want %b/%b/%b", o.pe, o.ne, o.ae, e.pe, e.ne, e.ae); end
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        sb.push_back(mk(4'b0000, 4'b0000, 4'b0000));
        o = obs(3); e = sb.pop_front(); n_vec++;
        if (o !== e) begin n_err++; $display("FAIL w4_release got pe/ne/ae=%b/%b/%b want %b/%b/%b", o.pe, o.ne, o.ae, e.pe, e.ne, e.ae); end
        k++;
        step(3, 4'b1111); sb.push_back(mk(4'b1111, 4'b0000, 4'b1111));
        o = obs(3); e = sb.pop_front(); n_vec++;
        if (o !== e) begin n_err++; $display("FAIL w4[%0d] got pe/ne/ae=%b/%b/%b want %b/%b/%b", k, o.pe, o.ne, o.ae, e.pe, e.ne, e.ae); end
        k++;
        step(3, 4'b0110); sb.push_back(mk(4'b0000, 4'b0000, 4'b0000));
        o = obs(3); e = sb.pop_front(); n_vec++;
        if (o !== e) begin n_err++; $display("FAIL w4[%0d] got pe/ne/ae=%b/%b/%b want %b/%b/%b", k, o.pe, o.ne, o.ae, e.pe, e.ne, e.ae); end
        k++;
        step(3, 4'b0011); sb.push_back(mk(4'b0000, 4'b1001, 4'b1001));
        o = obs(3); e = sb.pop_front(); n_vec++;
        if (o !== e) begin n_err++; $display("FAIL w4[%0d] got pe/ne/ae=%b/%b/%b want %b/%b/%b", k, o.pe, o.ne, o.ae, e.pe, e.ne, e.ae); end
        k++;
        step(3, 4'b0011); sb.push_back(mk(4'b0001, 4'b0100, 4'b0101));
        o = obs(3); e = sb.pop_front(); n_vec++;
        if (o !== e) begin n_err++; $display("FAIL w4[%0d] got pe/ne/ae=%b/%b/%b want %b/%b/%b", k, o.pe, o.ne, o.ae, e.pe, e.ne, e.ae); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_rise_fall();
        test_sync_latency();
        test_reset_level();
        test_toggle();
        test_width4_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
